branch_resolver: RTL and testbench

Two-stage pipelined branch resolution unit for the integer core's execute stage. It accepts a conditional branch (RV32 B-type funct3, two register operands, PC, immediate, front-end prediction) over a valid/ready handshake. It evaluates the condition with signed/unsigned less-than and equality, computes the target, and returns taken, redirect PC and mispredict status two cycles later. It is the consumer side of the operand-compare path and replaces the ad-hoc branch decode around the comparator.

---
 rtl/branch_resolver.sv | 229 ++++++++++++++++++++++
 tb/tb_branch_resolver.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Two-stage pipelined resolver for RV32 conditional branches (B-type).
// S1 holds the accepted request and feeds the comparators and adders; S2
// holds the resolved result, which drives every result output.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready     request handshake
//   i_funct3              branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   i_rs1, i_rs2          operands
//   i_pc, i_imm           branch PC and sign-extended B-immediate
//   i_pred_taken          front-end prediction
//   i_flush               kill all in-flight entries at the next edge
//   o_valid / i_ready     result handshake
//   o_taken               branch condition true
//   o_redirect_pc         taken ? pc+imm : pc+4
//   o_mispredict          o_taken differs from the prediction
//   o_misalign            taken with target[1:0] != 0
//   o_illegal             funct3 is 010 or 011
//   o_branch_cnt          completed output handshakes  (BRANCH_STATS_EN)
//   o_mispred_cnt         completed mispredicted ones (BRANCH_STATS_EN)
//
// Configuration macro: BRANCH_STATS_EN. When undefined the counter ports are
// tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_pred_taken,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_taken,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_mispredict,
  output logic            o_misalign,
  output logic            o_illegal,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispred_cnt
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // S1: request register
  logic            s1_valid_q, s1_valid_d;
  logic [2:0]      s1_funct3_q, s1_funct3_d;
  logic [XLEN-1:0] s1_rs1_q, s1_rs1_d;
  logic [XLEN-1:0] s1_rs2_q, s1_rs2_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  logic            s1_pred_q, s1_pred_d;

  // S2: resolved result register
  logic            s2_valid_q, s2_valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            mispred_q, mispred_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;

  logic            in_hs;
  logic            s2_load;
  logic            cmp_eq, cmp_lt, cmp_ltu;
  logic            cond, illegal;
  logic [XLEN-1:0] target, pc_plus4;

  // S1 may accept whenever either stage has room or S2 drains this cycle.
  // This is a combinational path from i_ready, deliberately unaffected by i_flush.
  assign o_ready = ~s1_valid_q | ~s2_valid_q | i_ready;
  assign in_hs   = i_valid & o_ready;
  assign s2_load = s1_valid_q & (~s2_valid_q | i_ready);

  // Condition evaluation and address arithmetic from the S1 register.
  always_comb begin
    cmp_eq   = (s1_rs1_q == s1_rs2_q);
    cmp_lt   = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
    cmp_ltu  = (s1_rs1_q < s1_rs2_q);
    target   = s1_pc_q + s1_imm_q;          // carry discarded: modulo 2^XLEN
    pc_plus4 = s1_pc_q + XLEN'(4);
    cond     = 1'b0;
    illegal  = 1'b0;
    case (s1_funct3_q)
      F3_BEQ:  cond = cmp_eq;
      F3_BNE:  cond = ~cmp_eq;
      F3_BLT:  cond = cmp_lt;
      F3_BGE:  cond = ~cmp_lt;
      F3_BLTU: cond = cmp_ltu;
      F3_BGEU: cond = ~cmp_ltu;
      default: illegal = 1'b1;              // 010/011 are never taken
    endcase
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_funct3_d = s1_funct3_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_pc_d     = s1_pc_q;
    s1_imm_d    = s1_imm_q;
    s1_pred_d   = s1_pred_q;
    s2_valid_d  = s2_valid_q;
    taken_d     = taken_q;
    redirect_d  = redirect_q;
    mispred_d   = mispred_q;
    misalign_d  = misalign_q;
    illegal_d   = illegal_q;

    if (s2_load)  s1_valid_d = 1'b0;
    if (in_hs) begin
      s1_valid_d  = 1'b1;
      s1_funct3_d = i_funct3;
      s1_rs1_d    = i_rs1;
      s1_rs2_d    = i_rs2;
      s1_pc_d     = i_pc;
      s1_imm_d    = i_imm;
      s1_pred_d   = i_pred_taken;
    end

    if (i_ready)  s2_valid_d = 1'b0;
    if (s2_load)  s2_valid_d = 1'b1;

    // Result data only changes when a live entry lands, so it holds while
    // o_valid is low and while the consumer stalls.
    if (s2_load && !i_flush) begin
      taken_d    = cond;
      redirect_d = cond ? target : pc_plus4;
      mispred_d  = cond ^ s1_pred_q;
      misalign_d = cond & (|target[1:0]);
      illegal_d  = illegal;
    end

    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_funct3_q <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_pc_q     <= '0;
      s1_imm_q    <= '0;
      s1_pred_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      taken_q     <= 1'b0;
      redirect_q  <= '0;
      mispred_q   <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_funct3_q <= s1_funct3_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_pc_q     <= s1_pc_d;
      s1_imm_q    <= s1_imm_d;
      s1_pred_q   <= s1_pred_d;
      s2_valid_q  <= s2_valid_d;
      taken_q     <= taken_d;
      redirect_q  <= redirect_d;
      mispred_q   <= mispred_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
    end
  end

  assign o_valid       = s2_valid_q;
  assign o_taken       = taken_q;
  assign o_redirect_pc = redirect_q;
  assign o_mispredict  = mispred_q;
  assign o_misalign    = misalign_q;
  assign o_illegal     = illegal_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic        out_hs;

  assign out_hs = s2_valid_q & i_ready;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (out_hs) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispred_q) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`else
  assign o_branch_cnt  = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//
// Drives branch_resolver with directed and random branches and compares every
// cycle against a transaction-level model: a queue of in-flight results, each
// computed straight from the branch rules, tagged with the edge it was taken.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
  } req_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] rpc;
    logic        mis;
    logic        mal;
    logic        ill;
  } res_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    res_t        res;
  } obs_t;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_clk, i_rst_n, i_valid, o_ready, i_pred_taken, i_flush;
  logic        o_valid, i_ready, o_taken, o_mispredict, o_misalign, o_illegal;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1, i_rs2, i_pc, i_imm, o_redirect_pc;
  logic [31:0] o_branch_cnt, o_mispred_cnt;

  branch_resolver dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_pc(i_pc),
    .i_imm(i_imm), .i_pred_taken(i_pred_taken), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_taken(o_taken),
    .o_redirect_pc(o_redirect_pc), .o_mispredict(o_mispredict),
    .o_misalign(o_misalign), .o_illegal(o_illegal),
    .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  res_t        exp_q[$];
  int          cap_q[$];
  int          edge_n = 0;
  logic [31:0] m_bcnt = 0;
  logic [31:0] m_mcnt = 0;

  function automatic res_t ref_resolve(input req_t r);
    res_t        x;
    logic        c;
    logic [31:0] tgt;
    tgt = r.pc + r.imm;
    case (r.f3)
      3'd0:    c = (r.rs1 == r.rs2);
      3'd1:    c = (r.rs1 != r.rs2);
      3'd4:    c = ($signed(r.rs1) <  $signed(r.rs2));
      3'd5:    c = ($signed(r.rs1) >= $signed(r.rs2));
      3'd6:    c = (r.rs1 <  r.rs2);
      3'd7:    c = (r.rs1 >= r.rs2);
      default: c = 1'b0;
    endcase
    x.taken = c;
    x.rpc   = c ? tgt : r.pc + 32'd4;
    x.mis   = (c != r.pred);
    x.mal   = c && (tgt[1:0] != 2'b00);
    x.ill   = (r.f3 == 3'd2) || (r.f3 == 3'd3);
    return x;
  endfunction

  // What the model expects to see during the current cycle.
  function automatic obs_t predict(input logic rdy);
    obs_t p;
    p       = '0;
    p.ready = (exp_q.size() < 2) || rdy;
    p.valid = (exp_q.size() > 0) && (edge_n - cap_q[0] >= 1);
    if (exp_q.size() > 0) p.res = exp_q[0];
    return p;
  endfunction

  // Apply one cycle's handshakes to the model (called after the edge).
  task automatic commit(input logic v, input req_t r, input logic rdy,
                        input logic fl, input obs_t p);
    if (p.valid && rdy) begin
      m_bcnt++;
      if (exp_q[0].mis) m_mcnt++;
    end
    if (fl) begin
      exp_q.delete();
      cap_q.delete();
    end else begin
      if (p.valid && rdy) begin
        void'(exp_q.pop_front());
        void'(cap_q.pop_front());
      end
      if (v && p.ready) begin
        exp_q.push_back(ref_resolve(r));
        cap_q.push_back(edge_n);
      end
    end
  endtask

  // Drive one cycle at posedge+1, sample just before the next edge, return at posedge+1.
  task automatic step(input logic v, input req_t r, input logic rdy,
                      input logic fl, output obs_t o);
    i_valid = v; i_funct3 = r.f3; i_rs1 = r.rs1; i_rs2 = r.rs2;
    i_pc = r.pc; i_imm = r.imm; i_pred_taken = r.pred;
    i_ready = rdy; i_flush = fl;
    #1;
    o.ready     = o_ready;
    o.valid     = o_valid;
    o.res.taken = o_taken;
    o.res.rpc   = o_redirect_pc;
    o.res.mis   = o_mispredict;
    o.res.mal   = o_misalign;
    o.res.ill   = o_illegal;
    @(posedge i_clk);
    edge_n++;
    #1;
  endtask

  // Send one request into an empty pipe; report result and edges until o_valid.
  task automatic single(input req_t r, output res_t got, output int lat, output logic ok);
    obs_t p, o;
    p = predict(1'b1);
    step(1'b1, r, 1'b1, 1'b0, o);
    commit(1'b1, r, 1'b1, 1'b0, p);
    lat = 1; ok = 1'b0; got = '0;
    for (int i = 0; i < 8; i++) begin
      p = predict(1'b1);
      step(1'b0, r, 1'b1, 1'b0, o);
      commit(1'b0, r, 1'b1, 1'b0, p);
      if (o.valid) begin
        got = o.res; ok = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  function automatic req_t rand_req();
    req_t        r;
    logic [12:0] imm13;
    r.f3  = 3'($urandom_range(0, 7));
    r.rs1 = $urandom;
    case ($urandom_range(0, 4))
      0:       r.rs2 = r.rs1;
      1:       r.rs2 = 32'h8000_0000;
      2:       r.rs2 = 32'hFFFF_FFFF;
      3:       r.rs2 = r.rs1 ^ 32'h8000_0000;
      default: r.rs2 = $urandom;
    endcase
    r.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
    imm13 = 13'($urandom) & 13'h1FFE;
    r.imm = {{19{imm13[12]}}, imm13};
    r.pred = 1'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    #12;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    total++;
    if ({o_taken, o_mispredict, o_misalign, o_illegal, o_redirect_pc} !== 36'd0) begin
      bad++; $display("FAIL reset_result got t=%0b m=%0b a=%0b i=%0b pc=%h exp all 0",
                      o_taken, o_mispredict, o_misalign, o_illegal, o_redirect_pc);
    end
    total++;
    if ({o_branch_cnt, o_mispred_cnt} !== 64'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_branch_cnt, o_mispred_cnt);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic test_beq();
    res_t g; int lat; logic ok;
    single('{f3:3'd0, rs1:32'd5, rs2:32'd5, pc:32'h100, imm:32'h20, pred:1'b0}, g, lat, ok);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL beq_latency got=%0d ok=%0b exp=2", lat, ok); end
    total++;
    if (g !== '{taken:1'b1, rpc:32'h120, mis:1'b1, mal:1'b0, ill:1'b0}) begin
      bad++; $display("FAIL beq_result got=%h exp t=1 pc=120 mis=1 mal=0 ill=0", g);
    end
  endtask

  task automatic test_signed();
    res_t g; int lat; logic ok;
    req_t r;
    r = '{f3:3'd4, rs1:32'hFFFF_FFFF, rs2:32'd1, pc:32'h200, imm:32'h10, pred:1'b0};
    single(r, g, lat, ok);
    total++; if (!ok || g.taken !== 1'b1 || g.rpc !== 32'h210) begin
      bad++; $display("FAIL blt got t=%0b pc=%h exp t=1 pc=210", g.taken, g.rpc); end
    r.f3 = 3'd6;
    single(r, g, lat, ok);
    total++; if (!ok || g.taken !== 1'b0 || g.rpc !== 32'h204) begin
      bad++; $display("FAIL bltu got t=%0b pc=%h exp t=0 pc=204", g.taken, g.rpc); end
    r.f3 = 3'd7;
    single(r, g, lat, ok);
    total++; if (!ok || g.taken !== 1'b1 || g.rpc !== 32'h210) begin
      bad++; $display("FAIL bgeu got t=%0b pc=%h exp t=1 pc=210", g.taken, g.rpc); end
  endtask

  task automatic test_illegal();
    res_t g; int lat; logic ok;
    single('{f3:3'd3, rs1:32'd7, rs2:32'd7, pc:32'h300, imm:32'h42, pred:1'b1}, g, lat, ok);
    total++;
    if (!ok || g !== '{taken:1'b0, rpc:32'h304, mis:1'b1, mal:1'b0, ill:1'b1}) begin
      bad++; $display("FAIL illegal_011 got=%h exp t=0 pc=304 mis=1 mal=0 ill=1", g);
    end
    single('{f3:3'd2, rs1:32'd1, rs2:32'd2, pc:32'h400, imm:32'h8, pred:1'b0}, g, lat, ok);
    total++;
    if (!ok || g !== '{taken:1'b0, rpc:32'h404, mis:1'b0, mal:1'b0, ill:1'b1}) begin
      bad++; $display("FAIL illegal_010 got=%h exp t=0 pc=404 mis=0 mal=0 ill=1", g);
    end
  endtask

  task automatic test_wrap_misalign();
    res_t g; int lat; logic ok;
    single('{f3:3'd1, rs1:32'd1, rs2:32'd0, pc:32'hFFFF_FFFC, imm:32'd4, pred:1'b1}, g, lat, ok);
    total++;
    if (!ok || g !== '{taken:1'b1, rpc:32'h0, mis:1'b0, mal:1'b0, ill:1'b0}) begin
      bad++; $display("FAIL wrap got=%h exp t=1 pc=0 mis=0 mal=0", g);
    end
    single('{f3:3'd1, rs1:32'd1, rs2:32'd0, pc:32'hFFFF_FFFC, imm:32'd6, pred:1'b1}, g, lat, ok);
    total++;
    if (!ok || g !== '{taken:1'b1, rpc:32'h2, mis:1'b0, mal:1'b1, ill:1'b0}) begin
      bad++; $display("FAIL misalign got=%h exp t=1 pc=2 mal=1", g);
    end
  endtask

  task automatic test_back_to_back();
    req_t reqs[4];
    obs_t p, o;
    int   sent = 0, got = 0, stall = 0;
    logic first = 1'b0, saw_low = 1'b0, rdy, v;
    for (int i = 0; i < 4; i++)
      reqs[i] = '{f3:3'd0, rs1:32'(i), rs2:32'(i), pc:32'h1000 + 32'(16*i), imm:32'h40, pred:1'b1};
    for (int c = 0; c < 40 && got < 4; c++) begin
      v = (sent < 4);
      p = predict(1'b1);
      if (!first && p.valid) begin first = 1'b1; stall = 3; end
      rdy = (stall > 0) ? 1'b0 : 1'b1;
      p = predict(rdy);
      step(v, reqs[v ? sent : 0], rdy, 1'b0, o);
      total++; if (o.ready !== p.ready) begin bad++; $display("FAIL b2b_ready c=%0d got=%0b exp=%0b", c, o.ready, p.ready); end
      total++; if (o.valid !== p.valid) begin bad++; $display("FAIL b2b_valid c=%0d got=%0b exp=%0b", c, o.valid, p.valid); end
      if (p.valid) begin
        total++; if (o.res !== p.res) begin bad++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, o.res, p.res); end
      end
      if (!o.ready) saw_low = 1'b1;
      if (v && p.ready) sent++;
      if (p.valid && rdy) got++;
      if (stall > 0) stall--;
      commit(v, reqs[v ? sent - ((p.ready) ? 1 : 0) : 0], rdy, 1'b0, p);
    end
    total++; if (got != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got); end
    total++; if (!saw_low) begin bad++; $display("FAIL b2b_backpressure got ready_low=0 exp=1"); end
    total++; if (o_branch_cnt !== (STATS ? m_bcnt : 32'd0)) begin
      bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", o_branch_cnt, STATS ? m_bcnt : 32'd0); end
  endtask

  task automatic test_random();
    req_t r;
    obs_t p, o;
    logic v, rdy;
    for (int c = 0; c < 400; c++) begin
      r   = rand_req();
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6) || (c >= 390);
      if (c >= 390) v = 1'b0;
      p = predict(rdy);
      step(v, r, rdy, 1'b0, o);
      total++; if (o.ready !== p.ready) begin bad++; $display("FAIL rand_ready c=%0d got=%0b exp=%0b", c, o.ready, p.ready); end
      total++; if (o.valid !== p.valid) begin bad++; $display("FAIL rand_valid c=%0d got=%0b exp=%0b", c, o.valid, p.valid); end
      if (p.valid) begin
        total++; if (o.res !== p.res) begin bad++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, o.res, p.res); end
      end
      commit(v, r, rdy, 1'b0, p);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain got pending=%0d exp=0", exp_q.size()); end
    total++; if (o_branch_cnt !== (STATS ? m_bcnt : 32'd0)) begin
      bad++; $display("FAIL rand_bcnt got=%0d exp=%0d", o_branch_cnt, STATS ? m_bcnt : 32'd0); end
    total++; if (o_mispred_cnt !== (STATS ? m_mcnt : 32'd0)) begin
      bad++; $display("FAIL rand_mcnt got=%0d exp=%0d", o_mispred_cnt, STATS ? m_mcnt : 32'd0); end
  endtask

  task automatic test_flush();
    req_t r;
    obs_t p, o;
    logic [31:0] bc;
    r  = '{f3:3'd0, rs1:32'd9, rs2:32'd9, pc:32'h800, imm:32'h10, pred:1'b0};
    bc = STATS ? m_bcnt : 32'd0;
    for (int i = 0; i < 2; i++) begin
      p = predict(1'b0); step(1'b1, r, 1'b0, 1'b0, o); commit(1'b1, r, 1'b0, 1'b0, p);
    end
    p = predict(1'b0);
    step(1'b1, r, 1'b0, 1'b1, o);
    total++; if (o.ready !== 1'b0) begin bad++; $display("FAIL flush_full_ready got=%0b exp=0", o.ready); end
    total++; if (o.valid !== 1'b1) begin bad++; $display("FAIL flush_full_valid got=%0b exp=1", o.valid); end
    commit(1'b1, r, 1'b0, 1'b1, p);
    p = predict(1'b1);
    step(1'b0, r, 1'b1, 1'b0, o);
    total++; if (o.valid !== 1'b0 || o.ready !== 1'b1) begin
      bad++; $display("FAIL flush_after got v=%0b r=%0b exp v=0 r=1", o.valid, o.ready); end
    commit(1'b0, r, 1'b1, 1'b0, p);
    // A request handshaken in the flush cycle is discarded.
    p = predict(1'b1);
    step(1'b1, r, 1'b1, 1'b1, o);
    total++; if (o.ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", o.ready); end
    commit(1'b1, r, 1'b1, 1'b1, p);
    for (int i = 0; i < 3; i++) begin
      p = predict(1'b1);
      step(1'b0, r, 1'b1, 1'b0, o);
      total++; if (o.valid !== 1'b0) begin bad++; $display("FAIL flush_discard i=%0d got v=%0b exp=0", i, o.valid); end
      commit(1'b0, r, 1'b1, 1'b0, p);
    end
    total++; if (o_branch_cnt !== bc) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", o_branch_cnt, bc); end
  endtask

  task automatic test_async_reset();
    req_t r;
    obs_t p, o;
    res_t g; int lat; logic ok;
    r = '{f3:3'd1, rs1:32'd1, rs2:32'd2, pc:32'h900, imm:32'h20, pred:1'b0};
    for (int i = 0; i < 3; i++) begin
      p = predict(1'b1); step(1'b1, r, 1'b1, 1'b0, o); commit(1'b1, r, 1'b1, 1'b0, p);
    end
    total++; if (o_branch_cnt !== (STATS ? m_bcnt : 32'd0)) begin
      bad++; $display("FAIL prereset_cnt got=%0d exp=%0d", o_branch_cnt, STATS ? m_bcnt : 32'd0); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL prereset_valid got=%0b exp=1", o_valid); end
    #2;
    i_rst_n = 1'b0;
    #1;
    exp_q.delete(); cap_q.delete(); m_bcnt = 0; m_mcnt = 0;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL areset_hs got v=%0b r=%0b exp v=0 r=1", o_valid, o_ready); end
    total++;
    if ({o_taken, o_mispredict, o_misalign, o_illegal, o_redirect_pc} !== 36'd0) begin
      bad++; $display("FAIL areset_result got t=%0b pc=%h exp 0", o_taken, o_redirect_pc); end
    total++; if ({o_branch_cnt, o_mispred_cnt} !== 64'd0) begin
      bad++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", o_branch_cnt, o_mispred_cnt); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL areset_hold got v=%0b exp=0", o_valid); end
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    edge_n  = 0;
    single(r, g, lat, ok);
    total++; if (!ok || lat != 2 || g.rpc !== 32'h920) begin
      bad++; $display("FAIL postreset got lat=%0d pc=%h exp lat=2 pc=920", lat, g.rpc); end
    total++; if (o_branch_cnt !== (STATS ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL postreset_cnt got=%0d exp=%0d", o_branch_cnt, STATS ? 1 : 0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
    i_funct3 = '0; i_rs1 = '0; i_rs2 = '0; i_pc = '0; i_imm = '0; i_pred_taken = 1'b0;
    test_reset();
    test_beq();
    test_signed();
    test_illegal();
    test_wrap_misalign();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
